// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_pkg
// Shared definitions for the IJTAG test data register that drives the 19-bit
// IJTAG/functional data mux.
//   - chain_len()     : chain length for a given data width (data + select bit)
//   - SEL_BIT         : position of the select bit inside the chain
//   - guard_state_e   : shift-length guard states
//   - guard_decode()  : maps the shift counter value onto a guard state
// -----------------------------------------------------------------------------
package firebird7_in_gate1_tessent_tdr_pkg;

  localparam int DEF_WIDTH = 19;
  localparam int SEL_BIT   = 0;

  // The chain carries the data field plus one select bit.
  function automatic int chain_len(input int width);
    return width + 1;
  endfunction

  localparam int CHAIN_LEN = chain_len(DEF_WIDTH);

  typedef enum logic [1:0] {
    CLEAN = 2'd0,  // fewer than L shifts since the last capture/update
    ARMED = 2'd1,  // exactly L shifts: an update may be accepted
    OVER  = 2'd2   // more than L shifts (counter parked at L+1)
  } guard_state_e;

  function automatic guard_state_e guard_decode(input int unsigned cnt,
                                                input int unsigned len);
    if (cnt < len) begin
      return CLEAN;
    end else if (cnt == len) begin
      return ARMED;
    end else begin
      return OVER;
    end
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift_cnt.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_shift_cnt
// Saturating shift counter and guard-state decode for the TDR.
// Ports:
//   clk     in   clock (TCK)
//   srst    in   synchronous active-high reset
//   i_clr   in   restart counting (capture or update)
//   i_inc   in   one shift happened
//   o_cnt   out  current shift count, saturates at CHAIN_LEN+1
//   o_state out  guard state decoded from o_cnt
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_shift_cnt
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int CHAIN_LEN_P = CHAIN_LEN,
  parameter int CNT_W       = $clog2(CHAIN_LEN_P + 2)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output guard_state_e     o_state
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CHAIN_LEN_P + 1);

  logic [CNT_W-1:0] r_cnt_reg;
  logic [CNT_W-1:0] w_cnt_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_cnt_reg <= '0;
    end else begin
      r_cnt_reg <= w_cnt_next;
    end
  end

  // Saturating at L+1 keeps an overshift visible no matter how long the
  // shift runs; the counter never wraps back into ARMED.
  always_comb begin
    w_cnt_next = r_cnt_reg;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_inc && (r_cnt_reg != CNT_SAT)) begin
      w_cnt_next = r_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    o_cnt   = r_cnt_reg;
    o_state = guard_decode(int'(r_cnt_reg), CHAIN_LEN_P);
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_w19_ctl
// IJTAG test data register feeding the 19-bit IJTAG/functional data mux.
// Chain layout: bit 0 = select, bits [L-1:1] = data, shifted right (si enters
// at the top, so is bit 0). Updates after a shift of the wrong length are
// dropped when UPDATE_GUARD=1 and flagged on the sticky update_rejected.
// Ports:
//   ijtag_tck        in   clock, rising edge
//   ijtag_reset      in   synchronous active-high reset
//   ijtag_sel        in   TDR selected; qualifies ce/se/ue
//   ijtag_si         in   scan in
//   ijtag_ce         in   capture enable (highest priority)
//   ijtag_se         in   shift enable
//   ijtag_ue         in   update enable (lowest priority)
//   ijtag_so         out  scan out = chain bit 0
//   capture_data_in  in   mux data_out observed on capture
//   ijtag_data_out   out  update register data field
//   ijtag_select     out  update register select bit
//   update_rejected  out  sticky: a guarded update was dropped
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_w19_ctl
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int               WIDTH        = 19,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int               UPDATE_GUARD = 1
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_si,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] capture_data_in,
  output logic [WIDTH-1:0] ijtag_data_out,
  output logic             ijtag_select,
  output logic             update_rejected
);

  localparam int L     = chain_len(WIDTH);
  localparam int CNT_W = $clog2(L + 2);

  logic [L-1:0]     r_shift_reg;
  logic [WIDTH-1:0] r_upd_data_reg;
  logic             r_upd_sel_reg;
  logic             r_rejected_reg;

  logic             w_cap;
  logic             w_shift;
  logic             w_upd;
  logic             w_upd_accept;
  logic [CNT_W-1:0] w_cnt;
  guard_state_e     w_guard;

  // One operation per edge, ce > se > ue, all qualified by sel.
  assign w_cap   = ijtag_sel & ijtag_ce;
  assign w_shift = ijtag_sel & ijtag_se & ~ijtag_ce;
  assign w_upd   = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;

  assign w_upd_accept = w_upd & ((UPDATE_GUARD == 0) || (w_guard == ARMED));

  firebird7_in_gate1_tessent_tdr_shift_cnt #(
    .CHAIN_LEN_P (L),
    .CNT_W       (CNT_W)
  ) u_shift_cnt (
    .clk     (ijtag_tck),
    .srst    (ijtag_reset),
    .i_clr   (w_cap | w_upd),
    .i_inc   (w_shift),
    .o_cnt   (w_cnt),
    .o_state (w_guard)
  );

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      r_shift_reg    <= '0;
      r_upd_data_reg <= RESET_VALUE;
      r_upd_sel_reg  <= 1'b0;
      r_rejected_reg <= 1'b0;
    end else begin
      // Capture reads back the current select alongside the mux output so a
      // full readback shows both halves of the override.
      if (w_cap) begin
        r_shift_reg <= {capture_data_in, r_upd_sel_reg};
      end else if (w_shift) begin
        r_shift_reg <= {ijtag_si, r_shift_reg[L-1:1]};
      end

      if (w_upd_accept) begin
        r_upd_data_reg <= r_shift_reg[L-1:SEL_BIT+1];
        r_upd_sel_reg  <= r_shift_reg[SEL_BIT];
      end else if (w_upd) begin
        r_rejected_reg <= 1'b1;
      end
    end
  end

  assign ijtag_so        = r_shift_reg[0];
  assign ijtag_data_out  = r_upd_data_reg;
  assign ijtag_select    = r_upd_sel_reg;
  assign update_rejected = r_rejected_reg;

endmodule
